fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Byte-wide instruction fetch with a 2-entry prefetch buffer, redirect and halt.
module fetch_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] mem_address,
    output logic       mem_write_enable,
    output logic [7:0] mem_write_data,
    input  logic [7:0] mem_read_data,
    output logic       instr_valid,
    output logic [7:0] instr,
    output logic [7:0] instr_pc,
    input  logic       instr_ready,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_pc,
    output logic       halted
);

    logic [7:0]      fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [7:0]      inflight_pc_q, inflight_pc_d;
    logic [1:0][7:0] buf_data_q, buf_data_d;
    logic [1:0][7:0] buf_pc_q, buf_pc_d;
    logic [1:0]      count_q, count_d;
    logic            halted_q, halted_d;

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occupancy;
    logic [1:0] after_pop;
    logic       wr_sel;

    assign mem_address      = fetch_pc_q;
    assign mem_write_enable = 1'b0;
    assign mem_write_data   = 8'h00;
    assign instr_valid      = (count_q != 2'd0);
    assign instr            = buf_data_q[0];
    assign instr_pc         = buf_pc_q[0];
    assign halted           = halted_q;

    // A response is only accepted while not halted; once the halt byte lands, the trailing read is dropped.
    assign pop       = instr_valid && instr_ready;
    assign push      = inflight_q && !halted_q && !redirect_valid;
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = !halted_q && !redirect_valid && (occupancy < 3'd2);
    assign after_pop = count_q - {1'b0, pop};
    assign wr_sel    = (after_pop != 2'd0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        buf_data_d    = buf_data_q;
        buf_pc_d      = buf_pc_q;
        count_d       = count_q + {1'b0, push} - {1'b0, pop};
        halted_d      = halted_q;

        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 8'd1;
        end

        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_pc_d[0]   = buf_pc_q[1];
        end

        if (push) begin
            buf_data_d[wr_sel] = mem_read_data;
            buf_pc_d[wr_sel]   = inflight_pc_q;
            if (mem_read_data == HALT_OPCODE) begin
                halted_d = 1'b1;
            end
        end

        // Redirect wins over everything else in the same cycle.
        if (redirect_valid) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 8'h00;
            buf_data_q    <= '0;
            buf_pc_q      <= '0;
            count_q       <= 2'd0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            buf_data_q    <= buf_data_d;
            buf_pc_q      <= buf_pc_d;
            count_q       <= count_d;
            halted_q      <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Directed bench for fetch_unit against a one-cycle-latency byte memory.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_address;
    logic       mem_write_enable;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_ready;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       halted;

    logic [7:0] mem [256];
    int vectors = 0;
    int miscompares = 0;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_ready      (instr_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_read_data <= mem[mem_address];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] exp_instr, input logic [7:0] exp_pc);
        check({tag, ".valid"}, {7'd0, instr_valid}, 8'd1);
        check({tag, ".instr"}, instr, exp_instr);
        check({tag, ".pc"}, instr_pc, exp_pc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h71; mem[8'h01] = 8'h75; mem[8'h02] = 8'h1A; mem[8'h03] = 8'hFF;
        mem[8'h04] = 8'h55; mem[8'h10] = 8'hA0; mem[8'h11] = 8'hA1;
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02;
        mem_read_data  = 8'h00;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst.valid", {7'd0, instr_valid}, 8'd0);
        check("rst.halted", {7'd0, halted}, 8'd0);
        check("rst.we", {7'd0, mem_write_enable}, 8'd0);
        check("rst.wdata", mem_write_data, 8'h00);
        check("rst.addr", mem_address, 8'h00);
        rst = 1'b0;

        // Straight-line program, consumer always ready
        tick();
        check("run.c1.valid", {7'd0, instr_valid}, 8'd0);
        tick(); check_head("run.0", 8'h71, 8'h00);
        tick(); check_head("run.1", 8'h75, 8'h01);
        tick(); check_head("run.2", 8'h1A, 8'h02);
        tick(); check_head("run.3", 8'hFF, 8'h03);
        check("run.halted", {7'd0, halted}, 8'd1);
        tick();
        check("run.after.valid", {7'd0, instr_valid}, 8'd0);
        tick();
        check("run.after2.valid", {7'd0, instr_valid}, 8'd0);
        check("run.after2.halted", {7'd0, halted}, 8'd1);

        // Back-pressure: buffer fills to two entries and fetch stalls
        do_reset();
        instr_ready = 1'b0;
        tick();
        tick(); check_head("bp.c2", 8'h71, 8'h00);
        tick(); check_head("bp.c3", 8'h71, 8'h00);
        check("bp.c3.addr", mem_address, 8'h02);
        tick();
        tick(); check_head("bp.c5", 8'h71, 8'h00);
        check("bp.c5.addr", mem_address, 8'h02);
        instr_ready = 1'b1;
        tick(); check_head("bp.1", 8'h75, 8'h01);
        tick(); check_head("bp.2", 8'h1A, 8'h02);
        tick(); check_head("bp.3", 8'hFF, 8'h03);
        tick();
        check("bp.after.valid", {7'd0, instr_valid}, 8'd0);

        // Redirect while the response for address 0 is in flight
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h10;
        tick();
        redirect_valid = 1'b0;
        check("rd.c0.valid", {7'd0, instr_valid}, 8'd0);
        check("rd.c0.addr", mem_address, 8'h10);
        tick();
        check("rd.c1.valid", {7'd0, instr_valid}, 8'd0);
        tick(); check_head("rd.0", 8'hA0, 8'h10);
        tick(); check_head("rd.1", 8'hA1, 8'h11);

        // Redirect with address wrap-around; run on into the halt byte
        mem[8'h00] = 8'h03;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        check("wr.c0.valid", {7'd0, instr_valid}, 8'd0);
        tick();
        tick(); check_head("wr.0", 8'h01, 8'hFE);
        tick(); check_head("wr.1", 8'h02, 8'hFF);
        tick(); check_head("wr.2", 8'h03, 8'h00);
        mem[8'h00] = 8'h71;
        tick(); check_head("wr.3", 8'h75, 8'h01);
        tick(); check_head("wr.4", 8'h1A, 8'h02);
        tick(); check_head("wr.5", 8'hFF, 8'h03);
        check("wr.halted", {7'd0, halted}, 8'd1);
        tick();
        check("wr.after.valid", {7'd0, instr_valid}, 8'd0);

        // Redirect out of the halted state
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        tick();
        redirect_valid = 1'b0;
        check("hr.halted", {7'd0, halted}, 8'd0);
        check("hr.addr", mem_address, 8'h00);
        check("hr.c0.valid", {7'd0, instr_valid}, 8'd0);
        tick();
        tick(); check_head("hr.0", 8'h71, 8'h00);
        tick(); check_head("hr.1", 8'h75, 8'h01);

        // Reset mid-stream with a full buffer
        instr_ready = 1'b0;
        tick(); check_head("mr.full", 8'h75, 8'h01);
        check("mr.full.addr", mem_address, 8'h03);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        instr_ready = 1'b1;
        check("mr.valid", {7'd0, instr_valid}, 8'd0);
        check("mr.addr", mem_address, 8'h00);
        check("mr.halted", {7'd0, halted}, 8'd0);
        tick();
        check("mr.c1.valid", {7'd0, instr_valid}, 8'd0);
        tick(); check_head("mr.0", 8'h71, 8'h00);
        check("mr.we", {7'd0, mem_write_enable}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
